fb_pixel_writer: RTL and testbench
==================================

// Module: fb_pixel_writer
// PURPOSE
//  Sink for sprite/scene pixel streams (X, Y, color_index): buffers pixels, drops
//  off-screen and transparent ones, writes the rest into the frame-buffer memory
//  over a req/ack port. Also runs a full-screen clear to a background index.
//  Sits between the sprite drawers (die, player, tiles) and the frame-buffer RAM.
// PARAMETERS
//  SCREEN_W     320    visible width, pixels
//  SCREEN_H     240    visible height, pixels
//  FIFO_DEPTH   8      pixel FIFO entries (power of 2)
//  TRANSPARENT  7'd0   color index never written (sprite background)
//  ADDR_W       17     frame-buffer address width (SCREEN_W*SCREEN_H <= 2**ADDR_W)
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high
//  pix_valid    in   1       pixel on pix_x/pix_y/pix_color valid
//  pix_ready    out  1       block can accept a pixel this cycle
//  pix_x        in   9       screen X
//  pix_y        in   8       screen Y
//  pix_color    in   7       palette index
//  clear_start  in   1       1-cycle pulse: start full-screen clear
//  clear_color  in   7       background index, sampled with clear_start
//  busy         out  1       FIFO non-empty, write outstanding, or clearing
//  clear_done   out  1       1-cycle pulse after last clear write acked
//  mem_addr     out  ADDR_W  write address = y*SCREEN_W + x
//  mem_data     out  7       write data (palette index)
//  mem_we       out  1       write request; held until mem_ack
//  mem_ack      in   1       memory accepted write this cycle
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_data=0, clear_done=0,
//   busy=0; pix_ready=1 the first cycle after reset. Reset mid-write abandons it.
//  States: IDLE (drain FIFO), CLR_WAIT (stop input, drain FIFO), CLR (sweep).
//  Input: transfer when pix_valid && pix_ready. pix_ready = !fifo_full && state==IDLE.
//   No full-FIFO bypass: a pop in the same cycle does not raise pix_ready.
//  Filter at input: x>=SCREEN_W, y>=SCREEN_H, or color==TRANSPARENT -> accepted
//   (handshake completes) but not pushed. Others pushed {x,y,color}.
//  Write port: mem_we/addr/data registered; while mem_we=1 and !mem_ack they hold
//   stable. On mem_ack the entry retires (FIFO pop); next entry may drive mem_we=1
//   with new addr the following cycle (back-to-back: one write per cycle max).
//  Input push to empty FIFO -> mem_we=1 no earlier than 1 cycle later (latency >=1).
//  Address arithmetic: y*SCREEN_W + x computed at full ADDR_W width, no truncation;
//   max 76799 for defaults.
//  clear_start in IDLE: latch clear_color, go CLR_WAIT; when FIFO empty and no write
//   outstanding -> CLR. clear_start in CLR_WAIT/CLR ignored.
//  CLR: mem_data=clear_color, mem_addr counts 0..SCREEN_W*SCREEN_H-1, advancing on
//   each mem_ack. On ack of last address: mem_we=0, clear_done=1 for one cycle,
//   counter wraps to 0, return IDLE (pix_ready=1 next cycle).
//  Simultaneous clear_start and pix_valid in IDLE: the pixel is accepted (written
//   before the clear); clear proceeds afterwards.
//  busy is combinational from state/FIFO/mem_we; low only when fully idle.
// TESTING
//  1. Push (x=5,y=2,c=9), mem_ack immediate -> one write addr=645 data=9; busy
//     drops after ack.
//  2. Push x=320,y=10,c=3; x=10,y=240,c=3; x=10,y=10,c=0 -> all accepted, zero
//     writes; busy stays 0.
//  3. mem_ack held 0 for 20 cycles, push 9 valid pixels -> 8 accepted, pix_ready=0,
//     mem_addr/data stable; release ack -> 8 writes in push order, one per cycle.
//  4. Push (319,239,c=127) -> addr=76799 data=127 (no width overflow).
//  5. 3 pixels queued then clear_start with clear_color=4 -> 3 pixel writes first,
//     then 76800 writes addr 0..76799 data=4, clear_done single pulse, pix_ready
//     low throughout, high the cycle after clear_done.
//  6. Assert reset mid-clear with mem_we=1 -> next cycle mem_we=0, busy=0,
//     clear_done=0, FIFO empty; new push writes normally.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// Pixel stream sink: filters, buffers and writes pixels to the frame buffer.
// Ports: pix_* stream in, clear_* full-screen clear, mem_* req/ack write port.
module fb_pixel_writer #(
  parameter int         SCREEN_W    = 320,
  parameter int         SCREEN_H    = 240,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [6:0] TRANSPARENT = 7'd0,
  parameter int         ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [8:0]        pix_x,
  input  logic [7:0]        pix_y,
  input  logic [6:0]        pix_color,
  input  logic              clear_start,
  input  logic [6:0]        clear_color,
  output logic              busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [6:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ack
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLR_WAIT = 2'd1;
  localparam logic [1:0] S_CLR      = 2'd2;

  localparam logic [ADDR_W-1:0] W_A =
    ADDR_W'(SCREEN_W);
  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [PW:0] FULL_N =
    (PW+1)'(FIFO_DEPTH);

  logic [1:0]    state;
  logic [23:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [6:0]    clr_color;

  logic          fifo_full;
  logic          on_screen;
  logic          push;
  logic          pop;
  logic          draining;
  logic [PW-1:0] next_idx;
  logic          next_avail;
  logic          load;
  logic [23:0]   next_ent;
  logic [ADDR_W-1:0] next_addr;

  assign fifo_full = (count == FULL_N);
  assign pix_ready = !fifo_full && (state == S_IDLE);
  assign on_screen = (pix_x < 9'(SCREEN_W)) &&
                     (pix_y < 8'(SCREEN_H));
  assign push = pix_valid && pix_ready && on_screen &&
                (pix_color != TRANSPARENT);

  // The head entry stays queued while its write is in flight and
  // retires on ack; the entry behind it is loaded in the same cycle
  // so acked writes can go back to back.
  assign draining   = (state != S_CLR);
  assign pop        = draining && mem_we && mem_ack;
  assign next_idx   = pop ? rd_ptr + PW'(1) : rd_ptr;
  assign next_avail = pop ? (count > (PW+1)'(1))
                          : (count != '0);
  assign load       = draining && (!mem_we || mem_ack) &&
                      next_avail;
  assign next_ent   = fifo_q[next_idx];
  assign next_addr  = ADDR_W'(next_ent[14:7]) * W_A +
                      ADDR_W'(next_ent[23:15]);

  assign busy = (state != S_IDLE) || (count != '0) || mem_we;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= {pix_x, pix_y, pix_color};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      clr_color  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase

      if (load) begin
        mem_we   <= 1'b1;
        mem_addr <= next_addr;
        mem_data <= next_ent[6:0];
      end else if (pop) begin
        mem_we <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (clear_start) begin
            clr_color <= clear_color;
            state     <= S_CLR_WAIT;
          end
        end
        S_CLR_WAIT: begin
          if (count == '0 && !mem_we) begin
            state    <= S_CLR;
            mem_we   <= 1'b1;
            mem_addr <= '0;
            mem_data <= clr_color;
          end
        end
        S_CLR: begin
          if (mem_ack) begin
            if (mem_addr == LAST_A) begin
              mem_we     <= 1'b0;
              mem_addr   <= '0;
              clear_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: random pixels vs. a queue-based model.
// Scoreboard of expected writes, popped by a negedge monitor.
module tb_fb_pixel_writer;

  logic        clk = 0;
  logic        reset = 1;
  logic        pix_valid = 0;
  logic        pix_ready;
  logic [8:0]  pix_x = 0;
  logic [7:0]  pix_y = 0;
  logic [6:0]  pix_color = 0;
  logic        clear_start = 0;
  logic [6:0]  clear_color = 0;
  logic        busy;
  logic        clear_done;
  logic [16:0] mem_addr;
  logic [6:0]  mem_data;
  logic        mem_we;
  logic        mem_ack = 0;

  fb_pixel_writer dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .clear_start(clear_start), .clear_color(clear_color),
    .busy(busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] a;
    logic [6:0]  d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  ack_mode = 0;
  bit  mon_en = 1;
  bit  in_clear = 0;
  int  viol = 0;
  int  done_cnt = 0;

  bit          hold_v = 0;
  logic [16:0] hold_a;
  logic [6:0]  hold_d;

  // memory acknowledge: 0 = never, 1 = always, 2 = random
  always begin
    @(posedge clk);
    #1;
    if (ack_mode == 2) mem_ack = 1'($urandom % 2);
    else mem_ack = (ack_mode == 1);
  end

  task automatic chk(input string nm, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset || !mon_en) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!mem_we || mem_addr != hold_a || mem_data != hold_d) begin
          errors++;
          $display("FAIL hold: we=%0d a=%0d d=%0d expected a=%0d d=%0d",
                   mem_we, mem_addr, mem_data, hold_a, hold_d);
        end
      end
      if (mem_we && mem_ack) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL write: unexpected a=%0d d=%0d",
                   mem_addr, mem_data);
        end else begin
          wr_t e;
          e = sb.pop_front();
          if (mem_addr != e.a || mem_data != e.d) begin
            errors++;
            $display("FAIL write: got a=%0d d=%0d expected a=%0d d=%0d",
                     mem_addr, mem_data, e.a, e.d);
          end
        end
      end
      hold_v = mem_we && !mem_ack;
      hold_a = mem_addr;
      hold_d = mem_data;
      if (clear_done) begin
        done_cnt++;
        in_clear = 0;
      end else if (in_clear && pix_ready) begin
        viol++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit visible(int x, int y, int c);
    return x < 320 && y < 240 && c != 0;
  endfunction

  task automatic expect_pix(int x, int y, int c);
    wr_t e;
    e.a = 17'(y * 320 + x);
    e.d = 7'(c);
    sb.push_back(e);
  endtask

  task automatic send(int x, int y, int c);
    bit ok = 0;
    pix_x = 9'(x);
    pix_y = 8'(y);
    pix_color = 7'(c);
    pix_valid = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pix_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      if (visible(x, y, c)) expect_pix(x, y, c);
    end else begin
      checks++;
      errors++;
      $display("FAIL send: pix_ready timeout got 0 expected 1");
    end
    tick();
    pix_valid = 0;
  endtask

  task automatic drain(int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    int a0, cyc;
    repeat (3) tick();
    reset = 0;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", pix_ready, 1);
    tick();

    // single pixel, immediate ack
    ack_mode = 1;
    send(5, 2, 9);
    drain(50);
    tick();
    chk("t1_busy", busy, 0);

    // filtered pixels produce no writes and no busy
    send(320, 10, 3);
    @(negedge clk);
    chk("t2_busy_x", busy, 0);
    send(10, 240, 3);
    @(negedge clk);
    chk("t2_busy_y", busy, 0);
    send(10, 10, 0);
    @(negedge clk);
    chk("t2_busy_c", busy, 0);
    repeat (3) tick();
    chk("t2_sb", sb.size(), 0);

    // bottom-right corner
    send(319, 239, 127);
    drain(50);

    // stalled memory: FIFO fills, write held stable
    ack_mode = 0;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) send(i * 3 + 1, i + 1, i + 1);
    pix_x = 9'd50;
    pix_y = 8'd50;
    pix_color = 7'd50;
    pix_valid = 1;
    a0 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pix_ready) a0++;
    end
    chk("t3_ready_full", a0, 0);
    tick();
    pix_valid = 0;
    repeat (10) tick();
    @(negedge clk);
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 1 * 320 + 1);
    chk("t3_data", mem_data, 1);
    ack_mode = 1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sb.size() == 0) break;
      cyc++;
    end
    chk("t3_cycles", cyc, 8);

    // random pixels with random acknowledge
    ack_mode = 2;
    for (int i = 0; i < 150; i++) begin
      int x, y, c;
      x = $urandom_range(0, 335);
      y = $urandom_range(0, 250);
      c = ($urandom % 5 == 0) ? 0 : $urandom_range(1, 127);
      send(x, y, c);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain(3000);

    // queued pixels, then clear (third pixel arrives with clear_start)
    ack_mode = 0;
    repeat (2) tick();
    send(7, 7, 11);
    send(8, 9, 12);
    pix_x = 9'd100;
    pix_y = 8'd200;
    pix_color = 7'd13;
    pix_valid = 1;
    clear_start = 1;
    clear_color = 7'd4;
    @(negedge clk);
    chk("t5_ready_sim", pix_ready, 1);
    expect_pix(100, 200, 13);
    for (int a = 0; a < 76800; a++) begin
      wr_t e;
      e.a = 17'(a);
      e.d = 7'd4;
      sb.push_back(e);
    end
    tick();
    pix_valid = 0;
    clear_start = 0;
    in_clear = 1;
    done_cnt = 0;
    viol = 0;
    tick();
    chk("t5_ready_wait", pix_ready, 0);
    ack_mode = 1;
    repeat (1000) tick();
    clear_start = 1;
    clear_color = 7'd9;
    tick();
    clear_start = 0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 80000) begin
      tick();
      cyc++;
    end
    chk("t5_done_seen", done_cnt, 1);
    chk("t5_sb", sb.size(), 0);
    chk("t5_done_pulse", clear_done, 0);
    chk("t5_ready_after", pix_ready, 1);
    chk("t5_ready_viol", viol, 0);
    repeat (3) tick();
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_busy", busy, 0);

    // reset in the middle of a clear
    mon_en = 0;
    ack_mode = 0;
    clear_start = 1;
    clear_color = 7'd5;
    tick();
    clear_start = 0;
    repeat (5) tick();
    chk("t6_we_pre", mem_we, 1);
    reset = 1;
    tick();
    reset = 0;
    sb.delete();
    in_clear = 0;
    chk("t6_we", mem_we, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", clear_done, 0);
    chk("t6_ready", pix_ready, 1);
    mon_en = 1;
    ack_mode = 1;
    send(100, 50, 17);
    drain(50);
    tick();
    chk("t6_busy_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
